rob_multiport: RTL and testbench
================================

# rob_multiport

Parametrised reorder buffer for the out-of-order core. It accepts up to DISP_W in-order allocations and CMPL_W out-of-order completions per cycle, and retires up to RET_W completed entries in program order from the head. On a mispredicted branch or an exception reaching the head, it flushes all younger state and redirects fetch. It sits between dispatch (allocation), the functional-unit writeback ports (completion) and the rename/architectural map (retirement).

## Interface
Parameters:
- NUM_ENTS, 64, entry count; power of two, ≥ 2·max(DISP_W, RET_W)
- DISP_W, 2, allocation lanes
- RET_W, 4, retire lanes
- CMPL_W, 4, completion lanes (one per FU)
- AREG_W, 5, architectural register index width
- PREG_W, 7, physical register index width
- IDX_W = $clog2(NUM_ENTS), derived

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  DISP_W  per-lane allocate request; lanes contiguous from lane 0
- alloc_areg  in  DISP_W×AREG_W  destination architectural register
- alloc_preg  in  DISP_W×PREG_W  destination physical register
- alloc_pc  in  DISP_W×32  instruction PC
- alloc_ready  out  1  free entries ≥ DISP_W and no flush in progress
- alloc_idx  out  DISP_W×IDX_W  index granted to lane i (tail+i mod NUM_ENTS)
- cmpl_valid  in  CMPL_W  completion strobe
- cmpl_idx  in  CMPL_W×IDX_W  completing entry
- cmpl_exc  in  CMPL_W  entry raised an exception
- cmpl_mispred  in  CMPL_W  branch entry mispredicted
- cmpl_tgt  in  CMPL_W×32  redirect target (valid when cmpl_exc or cmpl_mispred)
- ret_valid  out  RET_W  registered retire strobe, lanes contiguous from lane 0
- ret_areg / ret_preg / ret_pc  out  RET_W×(AREG_W / PREG_W / 32)  retired entry fields
- flush_valid  out  1  registered one-cycle redirect pulse
- flush_pc  out  32  redirect target
- flush_exc  out  1  1 = exception, 0 = mispredict
- count  out  IDX_W+1  occupied entries

## Operation
- State: head, tail (IDX_W bits, wrap modulo NUM_ENTS); count (IDX_W+1 bits); per entry: valid, done, exc, mispred, areg, preg, pc, tgt.
- Allocate: accepted only if alloc_ready is high. Lane i writes entry tail+i with valid=1 and done/exc/mispred cleared. tail advances by popcount(alloc_valid). alloc_valid with alloc_ready low is ignored.
- Complete: sets done, and ORs exc/mispred, on a valid entry. Completion to an invalid entry is ignored. Two lanes hitting the same index: flags ORed; tgt taken from the lowest lane that has a flag.
- Retire window: entries head..head+RET_W-1. Lane k retires if lanes 0..k are all valid and done and lanes 0..k-1 carry no flag. The window stops at the first not-done entry.
- Flagged entry in the window: it retires in its lane (ret_valid high) and is the last entry retired that cycle.
  - At the same edge all entries are invalidated and tail is set to the new head, so count becomes 0.
  - flush_valid pulses with flush_pc = tgt and flush_exc = exc. If both flags are set, exc wins.
- Flush cycle: while flush_valid is high, alloc_ready=0, and alloc and cmpl inputs are ignored.
- count_next = count + allocated − retired. On a flush edge, count becomes 0.
- Reset: head=tail=count=0; all valid/done cleared; ret_valid=0, flush_valid=0, flush_pc=0, flush_exc=0, ret_* data=0. alloc_ready=0 while rst is high.

## Timing
- alloc_ready and alloc_idx are combinational from the current count, tail and flush state. Same-cycle retirement does not raise alloc_ready.
- Allocation at edge N makes the entry visible to completion from cycle N+1.
- Completion at edge N+1 makes the entry retire-eligible at edge N+2. ret_valid is high in the cycle following N+2.
- Minimum alloc→ret_valid latency is 3 cycles.
- Full (count == NUM_ENTS − DISP_W + 1 or more): alloc_ready=0. Retirement still proceeds.
- Empty: ret_valid=0.
- Wrap: indices wrap modulo NUM_ENTS. Retire and allocate across the boundary in the same cycle are legal.
- Alloc, complete and retire in the same cycle are all legal, with no interaction except through count.
- rst mid-operation discards all entries at that edge. No ret_valid or flush_valid pulse occurs afterward.

## Test plan
- Reset, then alloc 2/cycle for 4 cycles, complete all 8 in reverse order → ret_valid 4'b1111 on two consecutive cycles, in PC order, count returns to 0.
- Fill to count=63 → alloc_ready=0 while retirement continues; retire 4 → alloc_ready returns next cycle; tail wraps to 0 correctly.
- Entries 0..3 done, entry 1 mispred with tgt=0x400 → ret_valid=4'b0011, flush_valid=1, flush_pc=0x400, flush_exc=0, count=0; alloc during the flush cycle ignored.
- Entry 0 with both exc and mispred set → flush_exc=1; same-index completion on two lanes with flags ORed.
- Head entry not done while entries 1..3 are done → ret_valid=0 until entry 0 completes, then 4'b1111.
- Assert rst with 10 entries in flight → next cycle count=0, ret_valid=0, flush_valid=0, alloc_idx lane 0 = 0.

Source files
------------

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: in-order allocate, out-of-order complete,
// in-order retire from the head, with flush/redirect on a flagged head entry.
module rob_multiport #(
  parameter int NUM_ENTS = 64,
  parameter int DISP_W   = 2,
  parameter int RET_W    = 4,
  parameter int CMPL_W   = 4,
  parameter int AREG_W   = 5,
  parameter int PREG_W   = 7,
  parameter int IDX_W    = $clog2(NUM_ENTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DISP_W-1:0]          alloc_valid,
  input  logic [DISP_W*AREG_W-1:0]   alloc_areg,
  input  logic [DISP_W*PREG_W-1:0]   alloc_preg,
  input  logic [DISP_W*32-1:0]       alloc_pc,
  output logic                       alloc_ready,
  output logic [DISP_W*IDX_W-1:0]    alloc_idx,
  input  logic [CMPL_W-1:0]          cmpl_valid,
  input  logic [CMPL_W*IDX_W-1:0]    cmpl_idx,
  input  logic [CMPL_W-1:0]          cmpl_exc,
  input  logic [CMPL_W-1:0]          cmpl_mispred,
  input  logic [CMPL_W*32-1:0]       cmpl_tgt,
  output logic [RET_W-1:0]           ret_valid,
  output logic [RET_W*AREG_W-1:0]    ret_areg,
  output logic [RET_W*PREG_W-1:0]    ret_preg,
  output logic [RET_W*32-1:0]        ret_pc,
  output logic                       flush_valid,
  output logic [31:0]                flush_pc,
  output logic                       flush_exc,
  output logic [IDX_W:0]             count
);

  localparam logic [IDX_W:0] ALLOC_MAX = (IDX_W+1)'(NUM_ENTS - DISP_W);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [NUM_ENTS-1:0] valid_q, valid_d, done_q, done_d, exc_q, exc_d, mis_q, mis_d;
  logic [AREG_W-1:0] areg_q [NUM_ENTS];
  logic [PREG_W-1:0] preg_q [NUM_ENTS];
  logic [31:0]       pc_q   [NUM_ENTS];
  logic [31:0]       tgt_q  [NUM_ENTS];

  logic [RET_W-1:0]        ret_valid_q;
  logic [RET_W*AREG_W-1:0] ret_areg_q;
  logic [RET_W*PREG_W-1:0] ret_preg_q;
  logic [RET_W*32-1:0]     ret_pc_q;
  logic                    flush_valid_q, flush_exc_q;
  logic [31:0]             flush_pc_q;

  logic [IDX_W-1:0] alloc_ent [DISP_W];
  logic [IDX_W-1:0] cmpl_ent  [CMPL_W];
  logic [IDX_W-1:0] ret_ent   [RET_W];
  logic [DISP_W-1:0] alloc_fire;
  logic [IDX_W:0]    alloc_cnt, ret_cnt;
  logic [RET_W-1:0]  ret_go;
  logic              flush_go;
  logic [IDX_W-1:0]  flush_ent;

  // Allocation is only offered when a full group of lanes fits and no redirect is in flight.
  assign alloc_ready = !rst && !flush_valid_q && (count_q <= ALLOC_MAX);
  assign alloc_fire  = alloc_ready ? alloc_valid : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DISP_W; gi++) begin : g_alloc
      assign alloc_ent[gi] = tail_q + IDX_W'(gi);
      assign alloc_idx[gi*IDX_W +: IDX_W] = alloc_ent[gi];
    end
    for (gi = 0; gi < CMPL_W; gi++) begin : g_cmpl
      assign cmpl_ent[gi] = cmpl_idx[gi*IDX_W +: IDX_W];
    end
    for (gi = 0; gi < RET_W; gi++) begin : g_ret
      assign ret_ent[gi] = head_q + IDX_W'(gi);
    end
  endgenerate

  // Pick the in-order retiring prefix of the head window; a flagged entry closes it.
  always_comb begin
    logic blocked;
    ret_go    = '0;
    ret_cnt   = '0;
    flush_go  = 1'b0;
    flush_ent = '0;
    blocked   = 1'b0;
    alloc_cnt = '0;
    for (int i = 0; i < DISP_W; i++) alloc_cnt = alloc_cnt + (IDX_W+1)'(alloc_fire[i]);
    for (int k = 0; k < RET_W; k++) begin
      if (!blocked && valid_q[ret_ent[k]] && done_q[ret_ent[k]]) begin
        ret_go[k] = 1'b1;
        ret_cnt   = ret_cnt + (IDX_W+1)'(1);
        if (exc_q[ret_ent[k]] || mis_q[ret_ent[k]]) begin
          flush_go  = 1'b1;
          flush_ent = ret_ent[k];
          blocked   = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

  // Per-entry status next state: complete, then retire, then allocate; a flush wipes everything.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    mis_d   = mis_q;
    if (!flush_valid_q) begin
      for (int j = 0; j < CMPL_W; j++) begin
        if (cmpl_valid[j] && valid_q[cmpl_ent[j]]) begin
          done_d[cmpl_ent[j]] = 1'b1;
          exc_d[cmpl_ent[j]]  = exc_d[cmpl_ent[j]] | cmpl_exc[j];
          mis_d[cmpl_ent[j]]  = mis_d[cmpl_ent[j]] | cmpl_mispred[j];
        end
      end
    end
    for (int k = 0; k < RET_W; k++) begin
      if (ret_go[k]) begin
        valid_d[ret_ent[k]] = 1'b0;
        done_d[ret_ent[k]]  = 1'b0;
      end
    end
    for (int i = 0; i < DISP_W; i++) begin
      if (alloc_fire[i]) begin
        valid_d[alloc_ent[i]] = 1'b1;
        done_d[alloc_ent[i]]  = 1'b0;
        exc_d[alloc_ent[i]]   = 1'b0;
        mis_d[alloc_ent[i]]   = 1'b0;
      end
    end
    if (flush_go) begin
      valid_d = '0;
      done_d  = '0;
    end
    head_d  = head_q + ret_cnt[IDX_W-1:0];
    tail_d  = flush_go ? head_d : tail_q + alloc_cnt[IDX_W-1:0];
    count_d = flush_go ? '0 : count_q + alloc_cnt - ret_cnt;
  end

  // Pointers, status bits and registered retire/flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      done_q        <= '0;
      exc_q         <= '0;
      mis_q         <= '0;
      ret_valid_q   <= '0;
      ret_areg_q    <= '0;
      ret_preg_q    <= '0;
      ret_pc_q      <= '0;
      flush_valid_q <= 1'b0;
      flush_pc_q    <= '0;
      flush_exc_q   <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      exc_q         <= exc_d;
      mis_q         <= mis_d;
      ret_valid_q   <= ret_go;
      for (int k = 0; k < RET_W; k++) begin
        ret_areg_q[k*AREG_W +: AREG_W] <= ret_go[k] ? areg_q[ret_ent[k]] : '0;
        ret_preg_q[k*PREG_W +: PREG_W] <= ret_go[k] ? preg_q[ret_ent[k]] : '0;
        ret_pc_q[k*32 +: 32]           <= ret_go[k] ? pc_q[ret_ent[k]] : '0;
      end
      flush_valid_q <= flush_go;
      if (flush_go) begin
        flush_pc_q  <= tgt_q[flush_ent];
        flush_exc_q <= exc_q[flush_ent];
      end
    end
  end

  // Entry payload storage; the lowest flagged completion lane wins the target (written last).
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISP_W; i++) begin
      if (alloc_fire[i]) begin
        areg_q[alloc_ent[i]] <= alloc_areg[i*AREG_W +: AREG_W];
        preg_q[alloc_ent[i]] <= alloc_preg[i*PREG_W +: PREG_W];
        pc_q[alloc_ent[i]]   <= alloc_pc[i*32 +: 32];
      end
    end
    for (int j = CMPL_W - 1; j >= 0; j--) begin
      if (!flush_valid_q && cmpl_valid[j] && valid_q[cmpl_ent[j]] &&
          (cmpl_exc[j] || cmpl_mispred[j])) begin
        tgt_q[cmpl_ent[j]] <= cmpl_tgt[j*32 +: 32];
      end
    end
  end

  assign ret_valid   = ret_valid_q;
  assign ret_areg    = ret_areg_q;
  assign ret_preg    = ret_preg_q;
  assign ret_pc      = ret_pc_q;
  assign flush_valid = flush_valid_q;
  assign flush_pc    = flush_pc_q;
  assign flush_exc   = flush_exc_q;
  assign count       = count_q;

endmodule

// File: tb/tb_rob_multiport.sv
// Directed scoreboard bench for rob_multiport.
module tb_rob_multiport;
  localparam int NE = 64, DW = 2, RW = 4, CW = 4, AW = 5, PW = 7, IW = 6;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0]    alloc_valid;
  logic [DW*AW-1:0] alloc_areg;
  logic [DW*PW-1:0] alloc_preg;
  logic [DW*32-1:0] alloc_pc;
  logic             alloc_ready;
  logic [DW*IW-1:0] alloc_idx;
  logic [CW-1:0]    cmpl_valid, cmpl_exc, cmpl_mispred;
  logic [CW*IW-1:0] cmpl_idx;
  logic [CW*32-1:0] cmpl_tgt;
  logic [RW-1:0]    ret_valid;
  logic [RW*AW-1:0] ret_areg;
  logic [RW*PW-1:0] ret_preg;
  logic [RW*32-1:0] ret_pc;
  logic             flush_valid, flush_exc;
  logic [31:0]      flush_pc;
  logic [IW:0]      count;

  rob_multiport #(.NUM_ENTS(NE), .DISP_W(DW), .RET_W(RW), .CMPL_W(CW),
                  .AREG_W(AW), .PREG_W(PW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_areg(alloc_areg), .alloc_preg(alloc_preg),
    .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_exc(cmpl_exc),
    .cmpl_mispred(cmpl_mispred), .cmpl_tgt(cmpl_tgt),
    .ret_valid(ret_valid), .ret_areg(ret_areg), .ret_preg(ret_preg), .ret_pc(ret_pc),
    .flush_valid(flush_valid), .flush_pc(flush_pc), .flush_exc(flush_exc),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [AW-1:0] areg; logic [PW-1:0] preg; } ret_t;
  typedef struct packed { logic [31:0] pc; logic exc; } fl_t;
  ret_t exp_q[$];
  fl_t  fexp_q[$];
  ret_t re;
  fl_t  fe;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every retired lane and every flush pulse is matched against the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < RW; k++) begin
      if (ret_valid[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_retire: lane %0d pc %h, expected none", k, ret_pc[k*32 +: 32]);
        end else begin
          re = exp_q.pop_front();
          $display("retire lane %0d pc=%h areg=%0d preg=%0d", k, ret_pc[k*32 +: 32],
                   ret_areg[k*AW +: AW], ret_preg[k*PW +: PW]);
          check("ret_pc", 64'(ret_pc[k*32 +: 32]), 64'(re.pc));
          check("ret_areg", 64'(ret_areg[k*AW +: AW]), 64'(re.areg));
          check("ret_preg", 64'(ret_preg[k*PW +: PW]), 64'(re.preg));
        end
      end
    end
    if (flush_valid === 1'b1) begin
      if (fexp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_flush: pc %h, expected none", flush_pc);
      end else begin
        fe = fexp_q.pop_front();
        $display("flush pc=%h exc=%0d", flush_pc, flush_exc);
        check("flush_pc", 64'(flush_pc), 64'(fe.pc));
        check("flush_exc", 64'(flush_exc), 64'(fe.exc));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    alloc_valid = '0; cmpl_valid = '0; cmpl_exc = '0; cmpl_mispred = '0;
  endtask

  task automatic do_alloc(input int n, input logic [31:0] pc0, input logic [1:0] push);
    for (int i = 0; i < DW; i++) begin
      logic [31:0] p;
      p = pc0 + 32'(4 * i);
      if (i < n) begin
        alloc_valid[i] = 1'b1;
        alloc_pc[i*32 +: 32]  = p;
        alloc_areg[i*AW +: AW] = p[6:2];
        alloc_preg[i*PW +: PW] = p[8:2];
        if (push[i]) exp_q.push_back('{pc: p, areg: p[6:2], preg: p[8:2]});
      end
    end
  endtask

  task automatic set_cmpl(input int lane, input int idx, input logic e, input logic m,
                          input logic [31:0] t);
    cmpl_valid[lane] = 1'b1;
    cmpl_idx[lane*IW +: IW] = IW'(idx);
    cmpl_exc[lane] = e;
    cmpl_mispred[lane] = m;
    cmpl_tgt[lane*32 +: 32] = t;
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = '0; alloc_areg = '0; alloc_preg = '0; alloc_pc = '0;
    cmpl_valid = '0; cmpl_idx = '0; cmpl_exc = '0; cmpl_mispred = '0; cmpl_tgt = '0;

    // Reset state
    step(); step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_ret_valid", 64'(ret_valid), 64'd0);
    check("rst_flush_valid", 64'(flush_valid), 64'd0);
    check("rst_alloc_ready", 64'(alloc_ready), 64'd0);
    rst = 1'b0; #1;
    check("ready_after_rst", 64'(alloc_ready), 64'd1);
    check("alloc_idx0_after_rst", 64'(alloc_idx[IW-1:0]), 64'd0);
    check("alloc_idx1_after_rst", 64'(alloc_idx[2*IW-1:IW]), 64'd1);

    // 8 allocations, reverse-order completion, two full retire groups
    for (int c = 0; c < 4; c++) begin
      do_alloc(2, 32'h1000 + 32'(8 * c), 2'b11); step();
    end
    check("count_8", 64'(count), 64'd8);
    for (int l = 0; l < 4; l++) set_cmpl(l, 7 - l, 1'b0, 1'b0, 32'h0);
    step();
    for (int l = 0; l < 4; l++) set_cmpl(l, 3 - l, 1'b0, 1'b0, 32'h0);
    step();
    check("ret_blocked_by_head", 64'(ret_valid), 64'h0);
    step();
    check("ret_grp1", 64'(ret_valid), 64'hF);
    check("count_4", 64'(count), 64'd4);
    step();
    check("ret_grp2", 64'(ret_valid), 64'hF);
    check("count_0", 64'(count), 64'd0);
    step();
    check("ret_idle", 64'(ret_valid), 64'h0);

    // Mispredict on window lane 1 (entries 8..11 done, 9 mispredicted)
    do_alloc(2, 32'h2000, 2'b11); step();
    do_alloc(2, 32'h2008, 2'b00); step();
    set_cmpl(0, 8, 1'b0, 1'b0, 32'h0);
    set_cmpl(1, 9, 1'b0, 1'b1, 32'h400);
    set_cmpl(2, 10, 1'b0, 1'b0, 32'h0);
    set_cmpl(3, 11, 1'b0, 1'b0, 32'h0);
    fexp_q.push_back('{pc: 32'h400, exc: 1'b0});
    step();
    step();
    check("mp_ret_valid", 64'(ret_valid), 64'h3);
    check("mp_flush_valid", 64'(flush_valid), 64'd1);
    check("mp_count", 64'(count), 64'd0);
    check("mp_ready_in_flush", 64'(alloc_ready), 64'd0);
    do_alloc(2, 32'h2F00, 2'b00);
    step();
    check("mp_alloc_ignored", 64'(count), 64'd0);
    check("mp_ready_back", 64'(alloc_ready), 64'd1);
    check("mp_new_tail", 64'(alloc_idx[IW-1:0]), 64'd10);

    // Both flags on the head entry via two lanes hitting the same index
    do_alloc(2, 32'h3000, 2'b01); step();
    set_cmpl(0, 10, 1'b0, 1'b1, 32'h500);
    set_cmpl(1, 10, 1'b1, 1'b0, 32'h600);
    set_cmpl(2, 11, 1'b0, 1'b0, 32'h0);
    fexp_q.push_back('{pc: 32'h500, exc: 1'b1});
    step();
    step();
    check("exc_ret_valid", 64'(ret_valid), 64'h1);
    check("exc_count", 64'(count), 64'd0);
    step();
    check("exc_new_tail", 64'(alloc_idx[IW-1:0]), 64'd11);

    // Head not done blocks younger done entries
    do_alloc(2, 32'h4000, 2'b11); step();
    do_alloc(2, 32'h4008, 2'b11); step();
    for (int l = 0; l < 3; l++) set_cmpl(l, 12 + l, 1'b0, 1'b0, 32'h0);
    step();
    check("hold_a", 64'(ret_valid), 64'h0);
    step();
    check("hold_b", 64'(ret_valid), 64'h0);
    check("hold_count", 64'(count), 64'd4);
    set_cmpl(0, 11, 1'b0, 1'b0, 32'h0);
    step();
    check("hold_c", 64'(ret_valid), 64'h0);
    step();
    check("hold_release", 64'(ret_valid), 64'hF);
    check("hold_count0", 64'(count), 64'd0);

    // Fill to 63 across the index wrap, then drain
    for (int c = 0; c < 31; c++) begin
      do_alloc(2, 32'h10000 + 32'(8 * c), 2'b11); step();
    end
    check("fill_62_ready", 64'(alloc_ready), 64'd1);
    do_alloc(1, 32'h10000 + 32'(8 * 31), 2'b01); step();
    check("fill_count63", 64'(count), 64'd63);
    check("fill_not_ready", 64'(alloc_ready), 64'd0);
    for (int l = 0; l < 4; l++) set_cmpl(l, 15 + l, 1'b0, 1'b0, 32'h0);
    step();
    check("full_still_not_ready", 64'(alloc_ready), 64'd0);
    step();
    check("full_ret", 64'(ret_valid), 64'hF);
    check("full_count59", 64'(count), 64'd59);
    check("full_ready_back", 64'(alloc_ready), 64'd1);
    check("wrap_idx0", 64'(alloc_idx[IW-1:0]), 64'd14);
    check("wrap_idx1", 64'(alloc_idx[2*IW-1:IW]), 64'd15);
    for (int n = 0; n < 59; n += 4) begin
      for (int l = 0; l < 4; l++)
        if (n + l < 59) set_cmpl(l, (19 + n + l) % NE, 1'b0, 1'b0, 32'h0);
      step();
    end
    repeat (4) step();
    check("drain_count", 64'(count), 64'd0);

    // Reset with 10 entries in flight
    for (int c = 0; c < 5; c++) begin
      do_alloc(2, 32'h5000 + 32'(8 * c), 2'b00); step();
    end
    check("inflight_10", 64'(count), 64'd10);
    rst = 1'b1;
    step();
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_ret", 64'(ret_valid), 64'h0);
    check("midrst_flush", 64'(flush_valid), 64'd0);
    check("midrst_idx0", 64'(alloc_idx[IW-1:0]), 64'd0);
    check("midrst_ready", 64'(alloc_ready), 64'd0);
    rst = 1'b0;
    repeat (3) step();
    check("post_rst_count", 64'(count), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("flush_sb_empty", 64'(fexp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
